// File: rtl/cache_ctrl_if.sv
// CPU load/store port and backing-memory port of the direct-mapped cache controller.
// The controller uses the slave view; the CPU/memory environment uses the master view.
interface cache_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_hit;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready, cpu_hit,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready, cpu_hit,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped, one-word-per-block, write-back/write-allocate data cache controller
// with tag/valid/dirty/data arrays and wrapping hit/miss counters.
module cache_ctrl #(
  parameter int INDEX_BITS = 3,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  cache_ctrl_if.slave        bus,
  output logic [COUNT_W-1:0] hit_count,
  output logic [COUNT_W-1:0] miss_count,
  output logic [2:0]         state_dbg
);
  localparam int NBLK  = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPARE   = 3'd1,
    WRITEBACK = 3'd2,
    ALLOCATE  = 3'd3
  } state_e;

  state_e              state_q, state_d;
  logic [29:0]         addr_q, addr_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                miss_q, miss_d;
  logic [31:0]         cpu_rdata_q, cpu_rdata_d;
  logic                cpu_ready_q, cpu_ready_d;
  logic                cpu_hit_q, cpu_hit_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [COUNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [COUNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic [NBLK-1:0]     valid_q, valid_d;
  logic [NBLK-1:0]     dirty_q, dirty_d;

  logic [31:0]         data_q [NBLK];
  logic [TAG_W-1:0]    tag_q  [NBLK];

  logic                  data_we;
  logic [31:0]           data_wval;
  logic                  tag_we;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag_lat;
  logic                  hit;

  // The latched word address supplies both index and tag for every phase of the access.
  assign idx     = addr_q[INDEX_BITS-1:0];
  assign tag_lat = addr_q[29:INDEX_BITS];
  assign hit     = valid_q[idx] && (tag_q[idx] == tag_lat);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    miss_d      = miss_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ready_d = 1'b0;
    cpu_hit_d   = cpu_hit_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    data_we     = 1'b0;
    data_wval   = wdata_q;
    tag_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr[31:2];
          we_d    = bus.cpu_we;
          wdata_d = bus.cpu_wdata;
          miss_d  = 1'b0;
          state_d = COMPARE;
        end
      end

      COMPARE: begin
        if (hit) begin
          if (we_q) begin
            data_we      = 1'b1;
            data_wval    = wdata_q;
            dirty_d[idx] = 1'b1;
          end else begin
            cpu_rdata_d = data_q[idx];
          end
          cpu_ready_d = 1'b1;
          cpu_hit_d   = ~miss_q;
          // An access that needed a fill counts as a miss even though its re-compare hits.
          if (miss_q) miss_cnt_d = miss_cnt_q + COUNT_W'(1);
          else        hit_cnt_d  = hit_cnt_q + COUNT_W'(1);
          state_d = IDLE;
        end else begin
          miss_d    = 1'b1;
          mem_req_d = 1'b1;
          if (valid_q[idx] && dirty_q[idx]) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[idx], idx, 2'b00};
            mem_wdata_d = data_q[idx];
            state_d     = WRITEBACK;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = {tag_lat, idx, 2'b00};
            state_d    = ALLOCATE;
          end
        end
      end

      WRITEBACK: begin
        // mem_req stays high straight into the fill request.
        if (bus.mem_ack) begin
          dirty_d[idx] = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = {tag_lat, idx, 2'b00};
          state_d      = ALLOCATE;
        end
      end

      ALLOCATE: begin
        if (bus.mem_ack) begin
          data_we      = 1'b1;
          data_wval    = bus.mem_rdata;
          tag_we       = 1'b1;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          mem_req_d    = 1'b0;
          state_d      = COMPARE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      miss_q      <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      cpu_hit_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      miss_q      <= miss_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_hit_q   <= cpu_hit_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
    end
  end

  // Data and tag storage keep their contents across reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (data_we) data_q[idx] <= data_wval;
    if (tag_we)  tag_q[idx]  <= tag_lat;
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.cpu_hit   = cpu_hit_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign hit_count     = hit_cnt_q;
  assign miss_count    = miss_cnt_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: a line-level cache/memory model predicts CPU responses
// and memory transactions; independent monitor and memory-responder processes check them.
module tb_cache_ctrl;
  localparam int IB = 3;
  localparam int CW = 16;
  localparam int NB = 1 << IB;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_ctrl_if bus();
  logic [CW-1:0] hit_count, miss_count;
  logic [2:0]    state_dbg;
  logic resp_ack = 1'b0;
  logic spur_ack = 1'b0;
  assign bus.mem_ack = resp_ack | spur_ack;

  cache_ctrl #(.INDEX_BITS(IB), .COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .hit_count(hit_count), .miss_count(miss_count), .state_dbg(state_dbg)
  );

  int n_chk = 0;
  int n_pass = 0;
  int ack_delay = -1;
  logic hold_ack = 1'b0;

  typedef struct { logic hit; logic ld; logic [31:0] rdata; } cpu_exp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mem_exp_t;
  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];

  // Reference model: each line remembers which memory word it holds.
  logic        m_valid [NB];
  logic        m_dirty [NB];
  logic [31:0] m_blk   [NB];
  logic [31:0] m_data  [NB];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] resp_mem  [logic [31:0]];
  int m_hits, m_misses;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic model_access(input logic we, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] wa;
    int i;
    logic h;
    cpu_exp_t c;
    mem_exp_t m;
    wa = a & ~32'h3;
    i  = int'((wa >> 2) % NB);
    h  = m_valid[i] && (m_blk[i] == wa);
    if (!h) begin
      if (m_valid[i] && m_dirty[i]) begin
        m.we = 1'b1; m.addr = m_blk[i]; m.wdata = m_data[i];
        mem_q.push_back(m);
        model_mem[m_blk[i]] = m_data[i];
      end
      m.we = 1'b0; m.addr = wa; m.wdata = '0;
      mem_q.push_back(m);
      m_data[i]  = model_mem.exists(wa) ? model_mem[wa] : dflt(wa);
      m_valid[i] = 1'b1;
      m_blk[i]   = wa;
      m_dirty[i] = 1'b0;
    end
    if (we) begin
      m_data[i]  = d;
      m_dirty[i] = 1'b1;
    end
    c.hit = h; c.ld = !we; c.rdata = m_data[i];
    cpu_q.push_back(c);
    if (h) m_hits++; else m_misses++;
  endtask

  // CPU-side monitor
  initial begin
    cpu_exp_t c;
    forever begin
      @(negedge clk);
      if (rst_n && bus.cpu_ready) begin
        if (cpu_q.size() == 0) begin
          n_chk++;
          $display("FAIL cpu_ready: unexpected completion, addr-independent, rdata %h", bus.cpu_rdata);
        end else begin
          c = cpu_q.pop_front();
          chk("cpu_hit", 32'(bus.cpu_hit), 32'(c.hit));
          if (c.ld) chk("cpu_rdata", bus.cpu_rdata, c.rdata);
        end
      end
    end
  end

  task automatic serve();
    mem_exp_t m;
    int d;
    logic [31:0] a;
    logic w;
    a = bus.mem_addr;
    w = bus.mem_we;
    if (mem_q.size() == 0) begin
      n_chk++;
      $display("FAIL mem_req: unexpected request addr %h we %0d, none required", a, w);
    end else begin
      m = mem_q.pop_front();
      chk("mem_we", 32'(w), 32'(m.we));
      chk("mem_addr", a, m.addr);
      if (m.we) chk("mem_wdata", bus.mem_wdata, m.wdata);
    end
    d = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
    repeat (d) @(negedge clk);
    while (hold_ack && rst_n) @(negedge clk);
    if (!rst_n || !bus.mem_req) return;
    chk("mem_addr_stable", bus.mem_addr, a);
    if (w) resp_mem[a] = bus.mem_wdata;
    else   bus.mem_rdata = resp_mem.exists(a) ? resp_mem[a] : dflt(a);
    resp_ack = 1'b1;
    @(negedge clk);
    resp_ack = 1'b0;
  endtask

  // Memory responder
  initial begin
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.mem_req) serve();
    end
  end

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d);
    model_access(we, a, d);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    @(negedge clk);
    bus.cpu_req = 1'b0;
  endtask

  task automatic wait_ready(output int lat);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus.cpu_ready) begin
        lat = c + 1;
        return;
      end
    end
    n_chk++;
    $display("FAIL ready_timeout: no cpu_ready within 200 cycles");
  endtask

  task automatic wait_state(input logic [2:0] s);
    for (int c = 0; c < 200; c++) begin
      if (state_dbg == s) return;
      @(negedge clk);
    end
    n_chk++;
    $display("FAIL state_timeout: state_dbg %0d never reached %0d", state_dbg, s);
  endtask

  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d, output int lat);
    issue(we, a, d);
    wait_ready(lat);
  endtask

  task automatic chk_counts(input string nm);
    chk({nm, "_hits"},   32'(hit_count),  32'(m_hits)   & 32'hFFFF);
    chk({nm, "_misses"}, 32'(miss_count), 32'(m_misses) & 32'hFFFF);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [26:0] tg;
    logic [31:0] a;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    chk("rst_cpu_hit", 32'(bus.cpu_hit), 32'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk_counts("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Cold load with a 2-cycle fill
    model_mem[32'h14] = 32'hA5;
    resp_mem[32'h14]  = 32'hA5;
    ack_delay = 2;
    access(1'b0, 32'h0000_0014, 32'h0, lat);
    chk("t1_miss_count", 32'(miss_count), 32'd1);

    // Same index, different tag, clean victim
    access(1'b0, 32'hFFFF_FC14, 32'h0, lat);
    chk("t2_miss_count", 32'(miss_count), 32'd2);

    // Store-allocate then two hitting loads
    access(1'b1, 32'hFFFF_FC1C, 32'd99, lat);
    access(1'b0, 32'hFFFF_FC1C, 32'h0, lat);
    chk("t3_hit_latency_a", 32'(lat), 32'd2);
    access(1'b0, 32'hFFFF_FC1C, 32'h0, lat);
    chk("t3_hit_latency_b", 32'(lat), 32'd2);
    chk("t3_hit_count", 32'(hit_count), 32'd2);

    // Dirty victim: write-back of 99 then fill; reload shows write-back data and clean line
    access(1'b0, 32'h0000_001C, 32'h0, lat);
    access(1'b0, 32'hFFFF_FC1C, 32'h0, lat);
    chk_counts("t4");

    // Reset while a fill is stalled
    ack_delay = 0;
    hold_ack = 1'b1;
    issue(1'b0, 32'h0000_0020, 32'h0);
    wait_state(3'd3);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_mem_req_async", 32'(bus.mem_req), 32'd0);
    chk("t5_state_async", 32'(state_dbg), 32'd0);
    hold_ack = 1'b0;
    cpu_q.delete();
    mem_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_counts("t5_rst");
    access(1'b0, 32'h0000_0020, 32'h0, lat);
    chk("t5_reload_miss", 32'(miss_count), 32'd1);

    // cpu_req pulse during ALLOCATE, then a spurious mem_ack in IDLE
    ack_delay = 4;
    issue(1'b0, 32'h0000_0040, 32'h0);
    wait_state(3'd3);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h0000_0060; bus.cpu_wdata = 32'h1234;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    wait_ready(lat);
    @(negedge clk);
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_state_idle", 32'(state_dbg), 32'd0);
    chk("t6_mem_req", 32'(bus.mem_req), 32'd0);
    chk("t6_no_pending", 32'(cpu_q.size()), 32'd0);
    chk_counts("t6");

    // Randomised traffic over a few colliding tags
    ack_delay = -1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0:       tg = 27'h0;
        1:       tg = 27'h1;
        2:       tg = 27'h2A5;
        default: tg = 27'h7FF_FFFF;
      endcase
      a = {tg, 3'($urandom_range(0, NB - 1)), 2'($urandom_range(0, 3))};
      access(1'($urandom_range(0, 1)), a, $urandom, lat);
    end
    repeat (2) @(negedge clk);
    chk_counts("final");
    chk("final_cpu_q_empty", 32'(cpu_q.size()), 32'd0);
    chk("final_mem_q_empty", 32'(mem_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
